// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types, FSM encoding and reset/bubble defaults.
package mips_pkg;
    typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} fetch_state_e;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory request/response handshake.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
    modport master (output req, addr, input ready, rdata);
    modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/if_fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, hold and flush-to-bubble.
module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic        load,
    input  ifid_t       word,
    output ifid_t       ifid,
    output logic [31:0] pc4
);
    ifid_t       ifid_d, ifid_q;
    logic [31:0] pc4_d, pc4_q;
    // bubbles keep the last pc/pc4 so ID sees a stable address
    always_comb begin
        ifid_d = ifid_q;
        pc4_d  = pc4_q;
        if (flush || (!hold && !load)) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end else if (!hold) begin
            ifid_d = word;
            pc4_d  = pc_plus4(word.pc);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q <= '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR};
            pc4_q  <= 32'd0;
        end else begin
            ifid_q <= ifid_d;
            pc4_q  <= pc4_d;
        end
    end
    assign ifid = ifid_q;
    assign pc4  = pc4_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, next-PC selection, imem handshake FSM and IF/ID register.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_stall,
    input  logic                IFID_flush,
    input  logic [31:0]         br_target,
    input  logic                lu_stall,
    if_fetch_stage_if.master    imem,
    output logic                ifid_valid,
    output logic [31:0]         ifid_pc,
    output logic [31:0]         ifid_pc4,
    output logic [31:0]         ifid_instr
);
    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q, pend_d, pend_q, skid_d, skid_q, skid_pc_d, skid_pc_q;
    logic [31:0]  tgt;
    logic         load;
    ifid_t        word, ifid;
    assign tgt       = br_target & ~32'd3;
    assign imem.req  = !rst && state_q != HOLD;
    assign imem.addr = pc_q;
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        load      = 1'b0;
        word      = '{valid: 1'b1, pc: pc_q, instr: imem.rdata};
        if (state_q == FETCH) begin
            if (pc_stall) begin
                if (imem.ready) pc_d = tgt;
                else begin
                    pend_d  = tgt;
                    state_d = DRAIN;
                end
            end else if (imem.ready) begin
                pc_d = pc_plus4(pc_q);
                if (lu_stall) begin
                    skid_d    = imem.rdata;
                    skid_pc_d = pc_q;
                    state_d   = HOLD;
                end else load = 1'b1;
            end
        end else if (state_q == DRAIN) begin
            if (pc_stall) pend_d = tgt;
            if (imem.ready) begin
                pc_d    = pc_stall ? tgt : pend_q;
                state_d = FETCH;
            end
        end else begin
            word = '{valid: 1'b1, pc: skid_pc_q, instr: skid_q};
            if (pc_stall) begin
                pc_d    = tgt;
                state_d = FETCH;
            end else if (!lu_stall) begin
                load    = 1'b1;
                state_d = FETCH;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            pend_q    <= 32'd0;
            skid_q    <= 32'd0;
            skid_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
        end
    end
    ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk  (clk),
        .rst  (rst),
        .flush(IFID_flush),
        .hold (lu_stall),
        .load (load),
        .word (word),
        .ifid (ifid),
        .pc4  (ifid_pc4)
    );
    assign ifid_valid = ifid.valid;
    assign ifid_pc    = ifid.pc;
    assign ifid_instr = ifid.instr;
endmodule
